mem_write_checker: RTL and testbench

- Self-checking monitor downstream of the 64-bit MIPS top's data-memory write port (memwrite, dataadr, writedata).
- Matches committed stores against programmable pass signatures and runs a cycle watchdog.
- Keeps a small FIFO log of stores for debug readout and reports sticky PASS/FAIL status.
- Synthesizable: usable in simulation and on-board alongside the core.

---
 rtl/mem_write_checker.sv | 193 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_checker
// Description : Store monitor for the data-memory write port of the 64-bit
//               MIPS core. Matches committed stores against three pass
//               signatures, runs a cycle watchdog, keeps a first-word
//               fall-through log of stores and reports sticky PASS/FAIL.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               memwrite/dataadr/writedata - store port from the core
//               log_pop           - pop head of store log
//               log_valid/log_adr/log_data/log_wide - head of store log
//               log_overflow      - sticky, a store was dropped (log full)
//               done/pass/fail/sig_id/cycles/wr_count - checker status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_checker #(
    parameter int          TIMEOUT   = 48,
    parameter int          CNTW      = 10,
    parameter int          LOGDEPTH  = 8,
    parameter logic [63:0] SIG0_ADR  = 64'd84,
    parameter logic [63:0] SIG0_DATA = 64'd7,
    parameter logic [63:0] SIG1_ADR  = 64'd128,
    parameter logic [63:0] SIG1_DATA = 64'd7,
    parameter logic [63:0] SIG2_ADR  = 64'd80,
    parameter logic [63:0] SIG2_DATA = 64'd1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      memwrite,
    input  logic [63:0]     dataadr,
    input  logic [63:0]     writedata,
    input  logic            log_pop,
    output logic            log_valid,
    output logic [63:0]     log_adr,
    output logic [63:0]     log_data,
    output logic            log_wide,
    output logic            log_overflow,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [1:0]      sig_id,
    output logic [CNTW-1:0] cycles,
    output logic [15:0]     wr_count
);

    localparam int              c_pw    = $clog2(LOGDEPTH);
    localparam logic [c_pw:0]   c_depth = (c_pw + 1)'(LOGDEPTH);
    localparam logic [CNTW-1:0] c_last  = CNTW'(TIMEOUT - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [CNTW-1:0] r_counter;
    logic [CNTW-1:0] r_cycles;
    logic [15:0]     r_wr_count;
    logic [1:0]      r_sig_id;

    logic            w_store;
    logic [63:0]     w_wdata;
    logic            w_m0, w_m1, w_m2;
    logic            w_hit;
    logic [1:0]      w_hit_id;

    // Store log storage and pointers
    logic [63:0]     r_log_adr  [LOGDEPTH];
    logic [63:0]     r_log_data [LOGDEPTH];
    logic            r_log_wide [LOGDEPTH];
    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic [c_pw:0]   r_count;
    logic            r_overflow;
    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;

    // Word stores carry their value in the low half; compare zero-extended.
    assign w_store = |memwrite;
    assign w_wdata = memwrite[1] ? writedata : {32'd0, writedata[31:0]};
    assign w_m0    = w_store && (dataadr == SIG0_ADR) && (w_wdata == SIG0_DATA);
    assign w_m1    = w_store && (dataadr == SIG1_ADR) && (w_wdata == SIG1_DATA);
    assign w_m2    = w_store && (dataadr == SIG2_ADR) && (w_wdata == SIG2_DATA);

    // Next-state logic; match has priority over the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_hit_id    = 2'd3;
        if (w_m0) begin
            w_hit    = 1'b1;
            w_hit_id = 2'd0;
        end else if (w_m1) begin
            w_hit    = 1'b1;
            w_hit_id = 2'd1;
        end else if (w_m2) begin
            w_hit    = 1'b1;
            w_hit_id = 2'd2;
        end
        case (r_state)
            S_RUN: begin
                if (w_hit) begin
                    w_state_nxt = S_PASS;
                end else if (r_counter == c_last) begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_PASS:  w_state_nxt = S_PASS;
            S_FAIL:  w_state_nxt = S_FAIL;
            default: w_state_nxt = S_FAIL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_counter  <= '0;
            r_cycles   <= '0;
            r_wr_count <= 16'd0;
            r_sig_id   <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RUN) begin
                r_counter <= r_counter + 1'b1;
                if (w_store && (r_wr_count != 16'hFFFF)) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
                // cycles captures the count before this edge's increment
                if (w_state_nxt == S_PASS) begin
                    r_sig_id <= w_hit_id;
                    r_cycles <= r_counter;
                end else if (w_state_nxt == S_FAIL) begin
                    r_cycles <= r_counter;
                end
            end
        end
    end

    // Log FIFO: a pop in the same cycle frees the slot for a push on a full log.
    assign w_push_req = (r_state == S_RUN) && w_store;
    assign w_pop      = log_pop && (r_count != '0);
    assign w_full     = (r_count == c_depth);
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_log_adr[r_wptr]  <= dataadr;
            r_log_data[r_wptr] <= writedata;
            r_log_wide[r_wptr] <= memwrite[1];
        end
    end

    assign log_valid    = (r_count != '0);
    assign log_adr      = r_log_adr[r_rptr];
    assign log_data     = r_log_data[r_rptr];
    assign log_wide     = r_log_wide[r_rptr];
    assign log_overflow = r_overflow;

    assign done     = (r_state != S_RUN);
    assign pass     = (r_state == S_PASS);
    assign fail     = (r_state == S_FAIL);
    assign sig_id   = r_sig_id;
    assign cycles   = r_cycles;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_checker
// Description : Self-checking bench for mem_write_checker. A queue-based
//               reference model tracks the checker outcome and the store log
//               from the signature rules; directed steps are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_checker;

    localparam int TIMEOUT  = 48;
    localparam int CNTW     = 10;
    localparam int LOGDEPTH = 8;

    logic            clk;
    logic            reset;
    logic [1:0]      memwrite;
    logic [63:0]     dataadr;
    logic [63:0]     writedata;
    logic            log_pop;

    logic            log_valid, log_wide, log_overflow, done, pass, fail;
    logic [63:0]     log_adr, log_data;
    logic [1:0]      sig_id;
    logic [CNTW-1:0] cycles;
    logic [15:0]     wr_count;

    logic            log_valid_b, log_wide_b, log_overflow_b, done_b, pass_b, fail_b;
    logic [63:0]     log_adr_b, log_data_b;
    logic [1:0]      sig_id_b;
    logic [CNTW-1:0] cycles_b;
    logic [15:0]     wr_count_b;

    mem_write_checker dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .log_pop(log_pop), .log_valid(log_valid),
        .log_adr(log_adr), .log_data(log_data), .log_wide(log_wide),
        .log_overflow(log_overflow), .done(done), .pass(pass), .fail(fail),
        .sig_id(sig_id), .cycles(cycles), .wr_count(wr_count)
    );

    // Signature 1 duplicates signature 0 to exercise lowest-index priority.
    mem_write_checker #(.SIG1_ADR(64'd84), .SIG1_DATA(64'd7)) dut_b (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .log_pop(log_pop), .log_valid(log_valid_b),
        .log_adr(log_adr_b), .log_data(log_data_b), .log_wide(log_wide_b),
        .log_overflow(log_overflow_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .sig_id(sig_id_b), .cycles(cycles_b), .wr_count(wr_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] adr;
        logic [63:0] data;
        logic        wide;
    } ent_t;

    ent_t q[$];
    int   m_phase;   // 0 running, 1 passed, 2 failed
    int   m_counter;
    int   m_cycles;
    int   m_wr;
    int   m_sig;
    bit   m_ovf;
    bit   chk_b;
    int   n_assert;
    int   n_fail;

    function automatic int sig_hit(logic [1:0] mw, logic [63:0] a, logic [63:0] d);
        logic [63:0] v;
        if (mw == 2'b00) return 3;
        v = mw[1] ? d : {32'd0, d[31:0]};
        if (a == 64'd84  && v == 64'd7) return 0;
        if (a == 64'd128 && v == 64'd7) return 1;
        if (a == 64'd80  && v == 64'd1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        q.delete();
        m_phase   = 0;
        m_counter = 0;
        m_cycles  = 0;
        m_wr      = 0;
        m_sig     = 3;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge();
        int   hit;
        ent_t e;
        if (reset) begin
            model_reset();
        end else begin
            if (log_pop && q.size() > 0) void'(q.pop_front());
            if (m_phase == 0 && memwrite != 2'b00) begin
                if (q.size() < LOGDEPTH) begin
                    e.adr  = dataadr;
                    e.data = writedata;
                    e.wide = memwrite[1];
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_phase == 0) begin
                hit = sig_hit(memwrite, dataadr, writedata);
                if (memwrite != 2'b00 && m_wr < 65535) m_wr++;
                if (hit < 3) begin
                    m_phase  = 1;
                    m_sig    = hit;
                    m_cycles = m_counter;
                end else if (m_counter == TIMEOUT - 1) begin
                    m_phase  = 2;
                    m_cycles = m_counter;
                end
                m_counter++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("done",     64'(done),         64'(m_phase != 0));
        chk("pass",     64'(pass),         64'(m_phase == 1));
        chk("fail",     64'(fail),         64'(m_phase == 2));
        chk("sig_id",   64'(sig_id),       64'(m_sig));
        chk("cycles",   64'(cycles),       64'(m_cycles));
        chk("wr_count", 64'(wr_count),     64'(m_wr));
        chk("valid",    64'(log_valid),    64'(q.size() > 0));
        chk("overflow", 64'(log_overflow), 64'(m_ovf));
        if (q.size() > 0) begin
            chk("log_adr",  log_adr,         q[0].adr);
            chk("log_data", log_data,        q[0].data);
            chk("log_wide", 64'(log_wide),   64'(q[0].wide));
        end
        if (chk_b) begin
            chk("prio_pass",   64'(pass_b),   64'd1);
            chk("prio_sig_id", 64'(sig_id_b), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        reset    = 1'b0;
        memwrite = 2'b00;
        log_pop  = 1'b0;
        dataadr  = 64'd0;
        writedata = 64'd0;
    endtask

    task automatic store(input logic [1:0] mw, input logic [63:0] a, input logic [63:0] d);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        tick();
        idle();
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Address that can never match a signature (odd).
    function automatic logic [63:0] nm_adr();
        return {$urandom, $urandom} | 64'd1;
    endfunction

    initial begin
        int guard;
        int sel;
        n_assert = 0;
        n_fail   = 0;
        chk_b    = 1'b0;
        model_reset();
        idle();

        // Signature 0 hit as a doubleword store; also priority on dut_b
        do_reset(2);
        repeat (3) tick();
        chk_b = 1'b1;
        store(2'b10, 64'd84, 64'd7);
        chk_b = 1'b0;
        log_pop = 1'b1;
        repeat (2) tick();
        idle();

        // Watchdog expiry, then stores are ignored
        do_reset(1);
        repeat (TIMEOUT + 2) tick();
        repeat (4) store(2'b10, 64'd84, 64'd7);

        // Near-miss followed by signature 2; drain the log in order
        do_reset(1);
        store(2'b01, 64'd84, 64'd6);
        store(2'b10, 64'd80, 64'd1);
        log_pop = 1'b1;
        repeat (3) tick();
        idle();

        // Match on the watchdog's final cycle wins
        do_reset(1);
        guard = 0;
        while (m_counter != TIMEOUT - 1 && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_last", 64'(m_counter), 64'(TIMEOUT - 1));
        store(2'b10, 64'd128, 64'd7);

        // Overflow: 10 stores, then push+pop on a full log
        do_reset(1);
        repeat (10) store(2'b10, nm_adr(), {$urandom, $urandom});
        log_pop = 1'b1;
        store(2'b01, nm_adr(), {$urandom, $urandom});
        log_pop = 1'b1;
        repeat (9) tick();
        idle();

        // Reset mid-run after three stores
        do_reset(1);
        repeat (3) store(2'b11, nm_adr(), {$urandom, $urandom});
        do_reset(1);

        // Randomized traffic, including upper-half garbage on word stores
        repeat (400) begin
            reset   = ($urandom_range(0, 59) == 0);
            log_pop = ($urandom_range(0, 2) == 0);
            memwrite = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
            sel = $urandom_range(0, 3);
            dataadr = (sel == 0) ? 64'd84 : (sel == 1) ? 64'd80 :
                      (sel == 2) ? 64'd128 : nm_adr();
            sel = $urandom_range(0, 4);
            writedata = (sel == 0) ? 64'd7 : (sel == 1) ? 64'd1 :
                        (sel == 2) ? {$urandom, 32'd7} :
                        (sel == 3) ? {$urandom, 32'd1} : {$urandom, $urandom};
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
